// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that time-shares one register_16 among NUM_CORES requesters.
// Each granted request runs IDLE -> ISSUE -> ACK, so exactly one register operation is in flight.
module shared_reg_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CORES-1:0]            req,
    input  logic [2*NUM_CORES-1:0]          op,
    input  logic [DATA_WIDTH*NUM_CORES-1:0] wdata,
    output logic [NUM_CORES-1:0]            ack,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            busy,
    output logic                            reg_write_en,
    output logic                            reg_inc_en,
    output logic                            reg_rst_en,
    output logic [DATA_WIDTH-1:0]           reg_data_in,
    input  logic [DATA_WIDTH-1:0]           reg_data_out
);

    localparam int IDX_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        gidx_q, gidx_d;
    logic [NUM_CORES-1:0]    ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    busy_q, busy_d;
    logic                    wen_q, wen_d;
    logic                    inc_q, inc_d;
    logic                    clr_q, clr_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;

    logic                    grant_vld;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W:0]          scan_sum;
    logic [1:0]              grant_op;
    logic [DATA_WIDTH-1:0]   grant_wdata;

    // Scan from ptr upward with wrap-around; the first set request wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            scan_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (scan_sum >= (IDX_W+1)'(NUM_CORES)) begin
                scan_sum = scan_sum - (IDX_W+1)'(NUM_CORES);
            end
            if (!grant_vld && req[scan_sum[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        grant_op    = '0;
        grant_wdata = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (grant_idx == IDX_W'(c)) begin
                grant_op    = op[2*c +: 2];
                grant_wdata = wdata[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            wen_q   <= 1'b0;
            inc_q   <= 1'b0;
            clr_q   <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            wen_q   <= wen_d;
            inc_q   <= inc_d;
            clr_q   <= clr_d;
            din_q   <= din_d;
        end
    end

    // The grant index is only consumed after a grant, so it needs no reset.
    always_ff @(posedge clk) begin
        gidx_q <= gidx_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_vld) state_d = S_ISSUE;
            S_ISSUE: state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        busy_d  = (state_d != S_IDLE);
        wen_d   = 1'b0;
        inc_d   = 1'b0;
        clr_d   = 1'b0;
        din_d   = din_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    gidx_d = grant_idx;
                    din_d  = grant_wdata;
                    wen_d  = (grant_op == 2'b01);
                    inc_d  = (grant_op == 2'b10);
                    clr_d  = (grant_op == 2'b11);
                end
            end
            S_ISSUE: begin
                for (int c = 0; c < NUM_CORES; c++) begin
                    ack_d[c] = (gidx_q == IDX_W'(c));
                end
            end
            S_ACK: begin
                rdata_d = reg_data_out;
                ptr_d   = (gidx_q == IDX_W'(NUM_CORES-1)) ? '0 : gidx_q + 1'b1;
            end
            default: ;
        endcase
    end

    // register_16 only shows its post-update value during ACK; its data_out is itself a flop,
    // so forwarding it here keeps rdata register-driven while holding the last value otherwise.
    assign rdata        = (state_q == S_ACK) ? reg_data_out : rdata_q;
    assign ack          = ack_q;
    assign busy         = busy_q;
    assign reg_write_en = wen_q;
    assign reg_inc_en   = inc_q;
    assign reg_rst_en   = clr_q;
    assign reg_data_in  = din_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter with a behavioural register_16 attached.
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [2*N-1:0]   op;
    logic [W*N-1:0]   wdata;
    logic [N-1:0]     ack;
    logic [W-1:0]     rdata;
    logic             busy;
    logic             reg_write_en;
    logic             reg_inc_en;
    logic             reg_rst_en;
    logic [W-1:0]     reg_data_in;
    logic [W-1:0]     reg_data_out;
    logic [W-1:0]     reg_val = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shared_reg_arbiter #(.NUM_CORES(N), .DATA_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .op           (op),
        .wdata        (wdata),
        .ack          (ack),
        .rdata        (rdata),
        .busy         (busy),
        .reg_write_en (reg_write_en),
        .reg_inc_en   (reg_inc_en),
        .reg_rst_en   (reg_rst_en),
        .reg_data_in  (reg_data_in),
        .reg_data_out (reg_data_out)
    );

    // register_16 model: no reset of its own, increment wraps.
    always @(posedge clk) begin
        if (reg_rst_en)        reg_val <= '0;
        else if (reg_write_en) reg_val <= reg_data_in;
        else if (reg_inc_en)   reg_val <= reg_val + 16'd1;
    end
    assign reg_data_out = reg_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input int c, input logic [1:0] o, input logic [W-1:0] d);
        req[c]         = 1'b1;
        op[2*c +: 2]   = o;
        wdata[W*c +: W] = d;
    endtask

    // Starts at an IDLE negedge, ends at the IDLE negedge after the ack.
    task automatic do_op(input int c, input logic [1:0] o, input logic [W-1:0] d,
                         input logic [2:0] en_exp, input logic [W-1:0] rd_exp, input string tag);
        set_core(c, o, d);
        chk({tag, ".idle_busy"}, busy, 0);
        @(negedge clk);
        chk({tag, ".issue_en"}, {reg_write_en, reg_inc_en, reg_rst_en}, en_exp);
        chk({tag, ".issue_din"}, reg_data_in, d);
        chk({tag, ".issue_busy"}, busy, 1);
        chk({tag, ".issue_ack"}, ack, 0);
        @(negedge clk);
        chk({tag, ".ack"}, ack, 4'b0001 << c);
        chk({tag, ".rdata"}, rdata, rd_exp);
        chk({tag, ".ack_en"}, {reg_write_en, reg_inc_en, reg_rst_en}, 0);
        req = '0;
        @(negedge clk);
        chk({tag, ".post_ack"}, ack, 0);
        chk({tag, ".rdata_hold"}, rdata, rd_exp);
        chk({tag, ".post_busy"}, busy, 0);
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        op    = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst.ack", ack, 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.busy", busy, 0);
        chk("rst.en", {reg_write_en, reg_inc_en, reg_rst_en}, 0);
        chk("rst.din", reg_data_in, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(1, 2'b01, 16'h000A, 3'b100, 16'h000A, "wr_c1");
        do_op(2, 2'b10, 16'h0000, 3'b010, 16'h000B, "inc_c2");
        do_op(2, 2'b00, 16'h0000, 3'b000, 16'h000B, "rd_c2");
        do_op(0, 2'b01, 16'hFFFF, 3'b100, 16'hFFFF, "wr_ffff");
        do_op(0, 2'b10, 16'h0000, 3'b010, 16'h0000, "inc_wrap");
        do_op(3, 2'b01, 16'h1234, 3'b100, 16'h1234, "wr_1234");
        do_op(3, 2'b11, 16'h0000, 3'b001, 16'h0000, "clr");

        // All four cores increment continuously from reset, register at 0.
        rst   = 1'b1;
        req   = 4'b1111;
        op    = 8'b10101010;
        wdata = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (2) @(negedge clk);
            chk("rr.ack", ack, 4'b0001 << (i % 4));
            chk("rr.rdata", rdata, i + 1);
            if (i < 4) begin
                @(negedge clk);
                chk("rr.gap", ack, 0);
            end
        end
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("rr_rst.busy", busy, 0);
        chk("rr_rst.rdata", rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // ptr becomes 3 after core2; then core3 must win over core0.
        do_op(2, 2'b00, 16'h0000, 3'b000, 16'h0005, "rd_ptr");
        set_core(3, 2'b01, 16'h0033);
        set_core(0, 2'b01, 16'h0044);
        @(negedge clk);
        chk("wrap.din3", reg_data_in, 16'h0033);
        @(negedge clk);
        chk("wrap.ack3", ack, 4'b1000);
        chk("wrap.rd3", rdata, 16'h0033);
        repeat (2) @(negedge clk);
        chk("wrap.din0", reg_data_in, 16'h0044);
        @(negedge clk);
        chk("wrap.ack0", ack, 4'b0001);
        chk("wrap.rd0", rdata, 16'h0044);
        req = '0;
        @(negedge clk);

        // Reset while core1's write is in flight: write lands, ack never appears.
        set_core(1, 2'b01, 16'h0055);
        @(negedge clk);
        chk("abort.en", {reg_write_en, reg_inc_en, reg_rst_en}, 3'b100);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.ack", ack, 0);
        chk("abort.busy", busy, 0);
        chk("abort.rdata", rdata, 0);
        rst = 1'b0;
        set_core(0, 2'b00, 16'h0000);
        @(negedge clk);
        chk("abort.issue0_en", {reg_write_en, reg_inc_en, reg_rst_en}, 3'b000);
        @(negedge clk);
        chk("abort.ack0", ack, 4'b0001);
        chk("abort.rd0", rdata, 16'h0055);
        repeat (2) @(negedge clk);
        chk("abort.issue1_en", {reg_write_en, reg_inc_en, reg_rst_en}, 3'b100);
        @(negedge clk);
        chk("abort.ack1", ack, 4'b0010);
        chk("abort.rd1", rdata, 16'h0055);
        req = '0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
